// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, 16x oversampling, 3-sample majority vote per bit.
// Holds the received byte until acknowledged; flags overrun (sticky) and framing errors (pulse).
module uart_rx #(
    parameter int unsigned CLK_HZ = 24000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned OSR    = 16
) (
    input  logic       clki,
    input  logic       rstn,
    input  logic       rx,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DIV = CLK_HZ / (BAUD * OSR);
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          rx_m;
    logic          rxs;
    logic [PW-1:0] psc;
    logic          tick;
    logic [3:0]    tc;
    logic [3:0]    tc_nxt;
    logic [2:0]    bidx;
    logic [1:0]    smp;
    logic          vote;
    logic          armed;
    logic [7:0]    sh;

    // Two-flop synchroniser for the asynchronous line, idle-high after reset
    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            rx_m <= 1'b1;
            rxs  <= 1'b1;
        end else begin
            rx_m <= rx;
            rxs  <= rx_m;
        end
    end

    // tc_nxt is the tick index being entered; samples at 7,8 plus live rxs at 9
    assign tick   = (psc == PW'(DIV - 1));
    assign tc_nxt = tc + 4'd1;
    assign vote   = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);

    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            psc       <= '0;
            tc        <= 4'd0;
            bidx      <= 3'd0;
            smp       <= 2'b00;
            armed     <= 1'b0;
            sh        <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (ack) valid <= 1'b0;
            psc <= tick ? '0 : psc + 1'b1;

            case (state)
                IDLE: begin
                    if (rxs) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        // Phase-align bit timing to the detected start edge
                        state <= START;
                        busy  <= 1'b1;
                        tc    <= 4'd0;
                        psc   <= '0;
                        armed <= 1'b0;
                    end
                end
                default: begin
                    if (tick) begin
                        tc <= tc_nxt;
                        if (tc_nxt == 4'd7) smp[0] <= rxs;
                        if (tc_nxt == 4'd8) smp[1] <= rxs;
                        case (state)
                            START: begin
                                if (tc_nxt == 4'd9 && vote) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end else if (tc_nxt == 4'd0) begin
                                    state <= DATA;
                                    bidx  <= 3'd0;
                                end
                            end
                            DATA: begin
                                if (tc_nxt == 4'd9) sh <= {vote, sh[7:1]};
                                if (tc_nxt == 4'd0) begin
                                    if (bidx == 3'd7) state <= STOP;
                                    else bidx <= bidx + 3'd1;
                                end
                            end
                            STOP: begin
                                if (tc_nxt == 4'd9) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    if (vote) begin
                                        // A completion overrides a coincident ack
                                        data  <= sh;
                                        valid <= 1'b1;
                                        if (valid && !ack) overrun <= 1'b1;
                                    end else begin
                                        frame_err <= 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized bytes and bit rates,
// checked against a frame-level reference model (last good byte, valid, sticky overrun).
module tb_uart_rx;

    logic       clki = 1'b0;
    logic       rstn = 1'b0;
    logic       rx   = 1'b1;
    logic       ack  = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cyc       = 0;
    int rise_cyc  = -1;
    int start_cyc = 0;
    int fe_cnt    = 0;
    logic valid_q = 1'b0;

    logic [7:0] exp_data    = 8'h00;
    logic       exp_valid   = 1'b0;
    logic       exp_overrun = 1'b0;

    uart_rx dut (
        .clki      (clki),
        .rstn      (rstn),
        .rx        (rx),
        .ack       (ack),
        .data      (data),
        .valid     (valid),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clki = ~clki;

    always @(posedge clki) cyc <= cyc + 1;

    // Count frame_err cycles and time the rising edge of valid
    always @(negedge clki) begin
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (valid && !valid_q) rise_cyc = cyc;
        valid_q = valid;
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clki);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit);
        start_cyc = cyc;
        rx = 1'b0;
        hold(per);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(per);
        end
        rx = stop_bit;
        hold(per);
    endtask

    task automatic model_good(input logic [7:0] b);
        if (exp_valid) exp_overrun = 1'b1;
        exp_data  = b;
        exp_valid = 1'b1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        hold(1);
        ack = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        rx   = 1'b1;
        ack  = 1'b0;
        hold(3);
        rstn = 1'b1;
        exp_data = 8'h00; exp_valid = 1'b0; exp_overrun = 1'b0;
        hold(5);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({data, valid, overrun, frame_err, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got data=%h v=%b o=%b fe=%b busy=%b exp all 0",
                     data, valid, overrun, frame_err, busy);
        end
    endtask

    task automatic test_basic();
        int fe0;
        int lat;
        fe0 = fe_cnt;
        rise_cyc = -1;
        send_frame(8'h55, 208, 1'b1);
        model_good(8'h55);
        lat = rise_cyc - start_cyc;
        checks++;
        if (rise_cyc < 0 || lat < 1985 || lat > 1998) begin
            errors++;
            $display("FAIL basic_latency got %0d exp 1985..1998 clki", lat);
        end
        checks++;
        if (data !== exp_data || valid !== exp_valid) begin
            errors++;
            $display("FAIL basic_data got %h/%b exp %h/%b", data, valid, exp_data, exp_valid);
        end
        checks++;
        if (fe_cnt !== fe0) begin
            errors++;
            $display("FAIL basic_frame_err got %0d pulses exp 0", fe_cnt - fe0);
        end
        do_ack();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack got valid=%b exp 0", valid);
        end
    endtask

    task automatic test_glitch();
        int s;
        int fe0;
        int k;
        fe0 = fe_cnt;
        s = cyc;
        rx = 1'b0;
        hold(40);
        rx = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_high got %b exp 1", busy);
        end
        k = 0;
        while (busy && k < 400) begin
            hold(1);
            k++;
        end
        checks++;
        if (busy !== 1'b0 || (cyc - s) < 112 || (cyc - s) > 128) begin
            errors++;
            $display("FAIL glitch_busy_len got %0d clki busy=%b exp 112..128 and 0", cyc - s, busy);
        end
        hold(20);
        checks++;
        if (valid !== exp_valid || data !== exp_data || fe_cnt !== fe0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_quiet got %h/%b fe=%0d busy=%b exp %h/%b fe=0 busy=0",
                     data, valid, fe_cnt - fe0, busy, exp_data, exp_valid);
        end
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'hA3, 208, 1'b0);
        checks++;
        if (fe_cnt - fe0 !== 1 || valid !== exp_valid || data !== exp_data) begin
            errors++;
            $display("FAIL ferr_pulse got fe=%0d %h/%b exp fe=1 %h/%b",
                     fe_cnt - fe0, data, valid, exp_data, exp_valid);
        end
        hold(2000);
        checks++;
        if (fe_cnt - fe0 !== 1 || busy !== 1'b0 || valid !== exp_valid) begin
            errors++;
            $display("FAIL ferr_break got fe=%0d busy=%b v=%b exp fe=1 busy=0 v=%b",
                     fe_cnt - fe0, busy, valid, exp_valid);
        end
        rx = 1'b1;
        hold(50);
        send_frame(8'h3C, 208, 1'b1);
        model_good(8'h3C);
        checks++;
        if (data !== exp_data || valid !== exp_valid || fe_cnt - fe0 !== 1) begin
            errors++;
            $display("FAIL ferr_recover got %h/%b exp %h/%b", data, valid, exp_data, exp_valid);
        end
        do_ack();
    endtask

    task automatic test_back_to_back();
        int d;
        int s2;
        send_frame(8'h12, 208, 1'b1);
        model_good(8'h12);
        send_frame(8'h34, 208, 1'b1);
        model_good(8'h34);
        checks++;
        if (data !== exp_data || valid !== exp_valid || overrun !== exp_overrun) begin
            errors++;
            $display("FAIL b2b_overrun got %h/%b/%b exp %h/%b/%b",
                     data, valid, overrun, exp_data, exp_valid, exp_overrun);
        end
        // Second pass: ack lands on the completion clki of the second frame
        apply_reset();
        rise_cyc = -1;
        send_frame(8'h12, 208, 1'b1);
        model_good(8'h12);
        d = rise_cyc - start_cyc;
        s2 = cyc;
        fork
            send_frame(8'h34, 208, 1'b1);
            begin
                repeat (d - 1) @(posedge clki);
                #1 ack = 1'b1;
                hold(1);
                ack = 1'b0;
            end
        join
        exp_data = 8'h34;
        exp_valid = 1'b1;
        checks++;
        if (data !== exp_data || valid !== exp_valid || overrun !== exp_overrun || s2 < 0) begin
            errors++;
            $display("FAIL b2b_ack_coincide got %h/%b/%b exp %h/%b/%b",
                     data, valid, overrun, exp_data, exp_valid, exp_overrun);
        end
    endtask

    task automatic test_reset_mid();
        fork
            send_frame(8'hFF, 208, 1'b1);
            begin
                hold(600);
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL rstmid_busy got %b exp 1", busy);
                end
                #2 rstn = 1'b0;
                #1;
                checks++;
                if ({data, valid, overrun, frame_err, busy} !== 12'h000) begin
                    errors++;
                    $display("FAIL rstmid_outputs got data=%h v=%b o=%b fe=%b busy=%b exp all 0",
                             data, valid, overrun, frame_err, busy);
                end
                hold(5);
                rstn = 1'b1;
                exp_data = 8'h00; exp_valid = 1'b0; exp_overrun = 1'b0;
            end
        join
        hold(20);
        send_frame(8'h81, 208, 1'b1);
        model_good(8'h81);
        checks++;
        if (data !== exp_data || valid !== exp_valid || overrun !== exp_overrun) begin
            errors++;
            $display("FAIL rstmid_recover got %h/%b/%b exp %h/%b/%b",
                     data, valid, overrun, exp_data, exp_valid, exp_overrun);
        end
        do_ack();
    endtask

    task automatic test_tolerance();
        int pers [2] = '{202, 214};
        int fe0;
        foreach (pers[i]) begin
            fe0 = fe_cnt;
            send_frame(8'hC6, pers[i], 1'b1);
            model_good(8'hC6);
            hold(10);
            checks++;
            if (data !== exp_data || valid !== exp_valid || fe_cnt !== fe0) begin
                errors++;
                $display("FAIL tol_%0d got %h/%b fe=%0d exp %h/%b fe=0",
                         pers[i], data, valid, fe_cnt - fe0, exp_data, exp_valid);
            end
            do_ack();
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int per;
        int fe0;
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            per = int'($urandom_range(202, 214));
            fe0 = fe_cnt;
            send_frame(b, per, 1'b1);
            model_good(b);
            hold(int'($urandom_range(1, 30)));
            checks++;
            if (data !== exp_data || valid !== exp_valid || overrun !== exp_overrun || fe_cnt !== fe0) begin
                errors++;
                $display("FAIL rand_%0d per=%0d got %h/%b/%b exp %h/%b/%b",
                         n, per, data, valid, overrun, exp_data, exp_valid, exp_overrun);
            end
            if ($urandom_range(0, 1) == 1) do_ack();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_tolerance();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
